// File: rtl/mem_port_responder.sv
// Memory-port responder: req/ack handshake in front of a word-addressed RAM plus
// two memory-mapped I/O words (output latch and synchronised input port).
module mem_port_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter logic [15:0] OUT_ADDR = 16'hFFFF,
  parameter logic [15:0] IN_ADDR  = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        err,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, wdata_q;
  logic [15:0] rdata_q, io_out_q;
  logic [15:0] sync1_q, sync2_q;
  logic [15:0] ram [DEPTH];

  logic        hit_ram, hit_out, hit_in;
  logic [15:0] read_val;

  // Decode always works on the latched request, so mid-transaction input changes are ignored.
  assign hit_ram = 32'(addr_q) < DEPTH;
  assign hit_out = addr_q == OUT_ADDR;
  assign hit_in  = addr_q == IN_ADDR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    err     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) state_d = we ? StWr : StRd;
      end
      StRd: begin
        state_d = StResp;
      end
      StWr: begin
        ack     = 1'b1;
        err     = !(hit_ram || hit_out);
        state_d = StIdle;
      end
      StResp: begin
        ack     = 1'b1;
        err     = !(hit_ram || hit_out || hit_in);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == StIdle && req) begin
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Two-flop synchroniser for the asynchronous input port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    read_val = 16'h0000;
    if (hit_ram) begin
      read_val = ram[addr_q[AW-1:0]];
    end else if (hit_out) begin
      read_val = io_out_q;
    end else if (hit_in) begin
      read_val = sync2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      io_out_q <= '0;
    end else begin
      if (state_q == StRd) rdata_q <= read_val;
      if (state_q == StWr && hit_out) io_out_q <= wdata_q;
    end
  end

  // RAM is not reset; an async reset drops state to idle, so a pending write never commits.
  always_ff @(posedge clk) begin
    if (state_q == StWr && hit_ram) ram[addr_q[AW-1:0]] <= wdata_q;
  end

  assign rdata  = rdata_q;
  assign io_out = io_out_q;
  assign busy   = state_q != StIdle;

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed self-checking bench for mem_port_responder: latency, decode, I/O words,
// back-to-back handshake and reset abort.
module tb_mem_port_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [15:0] addr, wdata;
  logic        ack, err, busy;
  logic [15:0] rdata, io_in, io_out;

  int n_total = 0;
  int n_bad   = 0;
  int ack_cnt = 0;

  mem_port_responder dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .ack    (ack),
    .rdata  (rdata),
    .err    (err),
    .io_in  (io_in),
    .io_out (io_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ack) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One handshake starting from idle; returns in the ack cycle with req already dropped.
  task automatic xfer(input logic w, input logic [15:0] a, input logic [15:0] d,
                      input int exp_lat, input string tag,
                      output logic [15:0] rd, output logic e);
    int cnt;
    @(posedge clk); #1;
    req = 1'b1; we = w; addr = a; wdata = d;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!ack && cnt < 10);
    check({tag, " latency"}, 32'(cnt), 32'(exp_lat));
    rd  = rdata;
    e   = err;
    req = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!ack && cnt < 10);
    check({tag, " ack seen"}, {31'b0, ack}, 32'd1);
  endtask

  initial begin
    logic [15:0] rd;
    logic        e;
    logic        any_ack;
    int          base;
    int          cnt;

    // T1: reset hold with a read request pending
    reset = 1'b1; req = 1'b1; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    io_in = 16'h0000;
    any_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      any_ack |= ack;
    end
    check("t1 ack during reset", {31'b0, any_ack}, 32'd0);
    check("t1 io_out", 32'(io_out), 32'h0);
    check("t1 rdata", 32'(rdata), 32'h0);
    check("t1 busy", {31'b0, busy}, 32'd0);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // T2: RAM write then read
    xfer(1'b1, 16'd5, 16'hBEEF, 1, "t2 wr", rd, e);
    check("t2 wr err", {31'b0, e}, 32'd0);
    xfer(1'b0, 16'd5, 16'h0000, 2, "t2 rd", rd, e);
    check("t2 rd data", 32'(rd), 32'hBEEF);
    check("t2 rd err", {31'b0, e}, 32'd0);

    // T3: output latch
    xfer(1'b1, 16'hFFFF, 16'h00A5, 1, "t3 wr", rd, e);
    check("t3 wr err", {31'b0, e}, 32'd0);
    @(posedge clk); #1;
    check("t3 io_out", 32'(io_out), 32'h00A5);
    xfer(1'b0, 16'hFFFF, 16'h0000, 2, "t3 rd", rd, e);
    check("t3 rd data", 32'(rd), 32'h00A5);

    // T4: input port through the synchroniser
    io_in = 16'h1234;
    repeat (3) @(posedge clk);
    xfer(1'b0, 16'hFFFE, 16'h0000, 2, "t4 rd", rd, e);
    check("t4 rd data", 32'(rd), 32'h1234);
    check("t4 rd err", {31'b0, e}, 32'd0);
    xfer(1'b1, 16'hFFFE, 16'h5555, 1, "t4 wr", rd, e);
    check("t4 wr err", {31'b0, e}, 32'd1);
    xfer(1'b0, 16'hFFFE, 16'h0000, 2, "t4 rd2", rd, e);
    check("t4 rd2 data", 32'(rd), 32'h1234);
    check("t4 io_out kept", 32'(io_out), 32'h00A5);

    // T5: unmapped addresses
    xfer(1'b1, 16'd0, 16'h1111, 1, "t5 wr0", rd, e);
    xfer(1'b0, 16'h8000, 16'h0000, 2, "t5 rd bad", rd, e);
    check("t5 rd bad data", 32'(rd), 32'h0);
    check("t5 rd bad err", {31'b0, e}, 32'd1);
    xfer(1'b1, 16'd1024, 16'h7777, 1, "t5 wr bad", rd, e);
    check("t5 wr bad err", {31'b0, e}, 32'd1);
    xfer(1'b0, 16'd0, 16'h0000, 2, "t5 rd0", rd, e);
    check("t5 ram0 kept", 32'(rd), 32'h1111);
    check("t5 rd0 err", {31'b0, e}, 32'd0);

    // T6: back-to-back writes with req held, then reset during a read
    @(posedge clk); #1;
    base = ack_cnt;
    req = 1'b1; we = 1'b1; addr = 16'd1; wdata = 16'hA001;
    wait_ack("t6 w1");
    addr = 16'd2; wdata = 16'hA002;
    wait_ack("t6 w2");
    addr = 16'd3; wdata = 16'hA003;
    wait_ack("t6 w3");
    we = 1'b0; addr = 16'd1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!(busy && !ack) && cnt < 10);
    check("t6 reached rd", {31'b0, busy && !ack}, 32'd1);
    reset = 1'b1;
    req   = 1'b0;
    #1;
    check("t6 busy after reset", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t6 ack count", 32'(ack_cnt - base), 32'd3);
    check("t6 idle", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    xfer(1'b0, 16'd1, 16'h0000, 2, "t6 rd1", rd, e);
    check("t6 ram1", 32'(rd), 32'hA001);
    xfer(1'b0, 16'd2, 16'h0000, 2, "t6 rd2", rd, e);
    check("t6 ram2", 32'(rd), 32'hA002);
    xfer(1'b0, 16'd3, 16'h0000, 2, "t6 rd3", rd, e);
    check("t6 ram3", 32'(rd), 32'hA003);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
